// File: rtl/psk8_pkg.sv
// Shared types and constants for the 8-PSK receive path.
package psk8_pkg;

  // One 8-PSK decision (Gray-coded constellation index).
  typedef logic [2:0] psk8_sym_t;

  // Receive sequencer states; encoding is visible on state_o.
  typedef enum logic [1:0] {
    PSK8_IDLE    = 2'd0,
    PSK8_HUNT    = 2'd1,
    PSK8_PAYLOAD = 2'd2
  } psk8_rx_state_e;

  // 000,011,110,101 with the oldest symbol in [11:9].
  localparam logic [11:0] PSK8_SYNC_DEFAULT = 12'h0F5;

  // Sync word length in symbols.
  localparam int unsigned PSK8_SYNC_SYMS = 4;

endpackage

// File: rtl/psk8_demodulator.sv
// Hard-decision 8-PSK slicer with a registered output.
// Ports: clk, rst_n (async active-low), i_in/q_in (5-bit signed decision
// point), sym (registered 3-bit Gray-coded decision).
module psk8_demodulator
  import psk8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [4:0] i_in,
  input  logic signed [4:0] q_in,
  output logic [2:0]        sym
);

  logic signed [5:0] i_ext;
  logic signed [5:0] q_ext;
  logic [5:0]        abs_i;
  logic [5:0]        abs_q;
  logic [8:0]        i_x5;
  logic [8:0]        q_x5;
  logic [8:0]        i_x2;
  logic [8:0]        q_x2;
  psk8_sym_t         dec_c;

  // Octant slicing: tan(22.5 deg) ~ 2/5 separates axis points from diagonals.
  always_comb begin
    i_ext = {i_in[4], i_in};
    q_ext = {q_in[4], q_in};
    abs_i = 6'(i_ext[5] ? -i_ext : i_ext);
    abs_q = 6'(q_ext[5] ? -q_ext : q_ext);
    i_x5  = 9'(abs_i) * 9'd5;
    q_x5  = 9'(abs_q) * 9'd5;
    i_x2  = 9'(abs_i) * 9'd2;
    q_x2  = 9'(abs_q) * 9'd2;
    dec_c = 3'b000;
    if (q_x5 < i_x2) begin
      dec_c = i_in[4] ? 3'b110 : 3'b000;
    end else if (i_x5 < q_x2) begin
      dec_c = q_in[4] ? 3'b101 : 3'b011;
    end else begin
      case ({i_in[4], q_in[4]})
        2'b00:   dec_c = 3'b001;
        2'b10:   dec_c = 3'b010;
        2'b11:   dec_c = 3'b111;
        default: dec_c = 3'b100;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sym <= '0;
    else        sym <= dec_c;
  end

endmodule

// File: rtl/psk8_sym_packer.sv
// Packs 3-bit symbols MSB-first into bytes.
// Ports: clk, rst_n, clear (drop partial bits), sym_valid/sym (symbol in),
// byte_valid/byte_data (registered one-cycle byte strobe and value).
module psk8_sym_packer
  import psk8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sym_valid,
  input  logic [2:0] sym,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int unsigned ACC_W = 10;
  localparam int unsigned CNT_W = 4;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W+2:0] cat_c;
  logic [CNT_W-1:0] cnt_sum_c;
  logic [CNT_W-1:0] shift_c;

  // acc holds cnt valid bits right-aligned; bits above cnt are don't-care.
  always_comb begin
    cat_c     = {acc, sym};
    cnt_sum_c = cnt + CNT_W'(3);
    shift_c   = cnt_sum_c - CNT_W'(8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else if (clear) begin
      acc        <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sym_valid) begin
        acc <= cat_c[ACC_W-1:0];
        if (cnt_sum_c >= CNT_W'(8)) begin
          byte_data  <= 8'(cat_c >> shift_c);
          byte_valid <= 1'b1;
          cnt        <= shift_c;
        end else begin
          cnt <= cnt_sum_c;
        end
      end
    end
  end

endmodule

// File: rtl/psk8_rx_controller.sv
// 8-PSK receive sequencer: symbol-rate decimation, sync hunt, payload packing
// and a one-deep valid/ready byte output.
// Ports: clk, rst_n (async active-low), en (low forces IDLE),
// sample_valid/i_in/q_in (sample stream), out_data/out_valid/out_ready
// (byte output), frame_start/frame_end (pulses), overflow (sticky drop flag),
// state_o (IDLE=0, HUNT=1, PAYLOAD=2).
module psk8_rx_controller
  import psk8_pkg::*;
#(
  parameter int unsigned SPS          = 4,
  parameter int unsigned STROBE_PHASE = 0,
  parameter logic [11:0] SYNC_WORD    = PSK8_SYNC_DEFAULT,
  parameter int unsigned FRAME_SYMS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sample_valid,
  input  logic signed [4:0] i_in,
  input  logic signed [4:0] q_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              frame_end,
  output logic              overflow,
  output logic [1:0]        state_o
);

  localparam int unsigned PH_W = 4;
  localparam int unsigned SC_W = 8;

  psk8_rx_state_e    state, state_n;
  logic [PH_W-1:0]   phase, phase_n;
  logic signed [4:0] sym_i, sym_q;
  logic              sv1, sv2;
  logic [11:0]       sync_sr, sync_sr_n;
  logic [2:0]        sync_cnt, sync_cnt_n;
  logic [SC_W-1:0]   sym_cnt, sym_cnt_n;
  logic              strobe_c;
  logic              fs_c, fe_c;
  logic              pk_clear_c, pk_sym_valid_c;
  logic [11:0]       hunt_sr_c;
  logic [2:0]        hunt_cnt_c;
  psk8_sym_t         dec_sym;
  logic              pk_byte_valid;
  logic [7:0]        pk_byte;

  psk8_demodulator u_demod (
    .clk   (clk),
    .rst_n (rst_n),
    .i_in  (sym_i),
    .q_in  (sym_q),
    .sym   (dec_sym)
  );

  psk8_sym_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear_c),
    .sym_valid  (pk_sym_valid_c),
    .sym        (dec_sym),
    .byte_valid (pk_byte_valid),
    .byte_data  (pk_byte)
  );

  // Next state, phase tracking and per-decision sync/payload bookkeeping.
  always_comb begin
    state_n        = state;
    phase_n        = phase;
    strobe_c       = 1'b0;
    sync_sr_n      = sync_sr;
    sync_cnt_n     = sync_cnt;
    sym_cnt_n      = sym_cnt;
    fs_c           = 1'b0;
    fe_c           = 1'b0;
    pk_clear_c     = 1'b0;
    pk_sym_valid_c = 1'b0;
    hunt_sr_c      = {sync_sr[8:0], dec_sym};
    hunt_cnt_c     = (sync_cnt == 3'd7) ? 3'd7 : sync_cnt + 3'd1;

    if (!en) begin
      state_n    = PSK8_IDLE;
      phase_n    = '0;
      sync_sr_n  = '0;
      sync_cnt_n = '0;
      sym_cnt_n  = '0;
      pk_clear_c = 1'b1;
    end else begin
      case (state)
        PSK8_IDLE: begin
          state_n = PSK8_HUNT;
          phase_n = '0;
        end
        PSK8_HUNT, PSK8_PAYLOAD: begin
          if (sample_valid) begin
            strobe_c = (phase == PH_W'(STROBE_PHASE));
            phase_n  = (phase == PH_W'(SPS - 1)) ? '0 : phase + PH_W'(1);
          end
          if (sv2) begin
            if (state == PSK8_HUNT) begin
              sync_sr_n  = hunt_sr_c;
              sync_cnt_n = hunt_cnt_c;
              if ((hunt_cnt_c >= 3'(PSK8_SYNC_SYMS)) && (hunt_sr_c == SYNC_WORD)) begin
                fs_c       = 1'b1;
                state_n    = PSK8_PAYLOAD;
                sym_cnt_n  = '0;
                pk_clear_c = 1'b1;
              end
            end else begin
              pk_sym_valid_c = 1'b1;
              if (sym_cnt == SC_W'(FRAME_SYMS - 1)) begin
                fe_c       = 1'b1;
                state_n    = PSK8_HUNT;
                sym_cnt_n  = '0;
                sync_sr_n  = '0;
                sync_cnt_n = '0;
              end else begin
                sym_cnt_n = sym_cnt + SC_W'(1);
              end
            end
          end
        end
        default: state_n = PSK8_IDLE;
      endcase
    end
  end

  // State and sequencer registers; the strobe I/Q latch survives en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PSK8_IDLE;
      phase       <= '0;
      sym_i       <= '0;
      sym_q       <= '0;
      sv1         <= 1'b0;
      sv2         <= 1'b0;
      sync_sr     <= '0;
      sync_cnt    <= '0;
      sym_cnt     <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      if (strobe_c) begin
        sym_i <= i_in;
        sym_q <= q_in;
      end
      sv1         <= en & strobe_c;
      sv2         <= en & sv1;
      sync_sr     <= sync_sr_n;
      sync_cnt    <= sync_cnt_n;
      sym_cnt     <= sym_cnt_n;
      frame_start <= fs_c;
      frame_end   <= fe_c;
    end
  end

  // One-deep output holding register; a byte arriving while stalled is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (!en) begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (pk_byte_valid) begin
      if (!out_valid || out_ready) begin
        out_data  <= pk_byte;
        out_valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_psk8_rx_controller.sv
// Randomized self-checking bench for psk8_rx_controller with a
// symbol-stream reference model and a byte scoreboard.
module tb_psk8_rx_controller;
  import psk8_pkg::*;

  localparam int unsigned SPS        = 4;
  localparam int unsigned FRAME_SYMS = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              sample_valid = 1'b0;
  logic signed [4:0] i_in = '0;
  logic signed [4:0] q_in = '0;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              frame_start;
  logic              frame_end;
  logic              overflow;
  logic [1:0]        state_o;

  always #5 clk = ~clk;

  psk8_rx_controller #(
    .SPS          (SPS),
    .STROBE_PHASE (0),
    .SYNC_WORD    (PSK8_SYNC_DEFAULT),
    .FRAME_SYMS   (FRAME_SYMS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_valid (sample_valid),
    .i_in         (i_in),
    .q_in         (q_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .overflow     (overflow),
    .state_o      (state_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: one cycle in 8
  int ready_k = 0;

  // Reference model state
  psk8_sym_t  win_q[$];
  bit         bits_q[$];
  logic [7:0] exp_q[$];
  bit         in_pay = 1'b0;
  int         pay_n = 0;
  int         fs_exp = 0, fe_exp = 0, fs_seen = 0, fe_seen = 0;
  int         strobe_cyc = 0, exp_fs_cyc = -1, fe_cyc = 0, last_acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ((cyc % 8) == ready_k);
    endcase
  end

  // Scoreboard and pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) begin
        fs_seen++;
        check("fs_latency", 32'(cyc), 32'(exp_fs_cyc));
      end
      if (frame_end) begin
        fe_seen++;
        fe_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) check("byte_unexpected", {24'd0, out_data}, 32'h100);
        else                   check("byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [9:0] point(input psk8_sym_t s);
    logic signed [4:0] pi, pq;
    case (s)
      3'b000:  begin pi =  5'sd4; pq =  5'sd0; end
      3'b001:  begin pi =  5'sd3; pq =  5'sd3; end
      3'b011:  begin pi =  5'sd0; pq =  5'sd4; end
      3'b010:  begin pi = -5'sd3; pq =  5'sd3; end
      3'b110:  begin pi = -5'sd4; pq =  5'sd0; end
      3'b111:  begin pi = -5'sd3; pq = -5'sd3; end
      3'b101:  begin pi =  5'sd0; pq = -5'sd4; end
      default: begin pi =  5'sd3; pq = -5'sd3; end
    endcase
    return {pi, pq};
  endfunction

  task automatic model_clear();
    win_q.delete();
    bits_q.delete();
    in_pay = 1'b0;
    pay_n  = 0;
  endtask

  task automatic model_abort();
    model_clear();
    exp_q.delete();
  endtask

  // Sync = last four symbols since the last clear spell the sync word;
  // payload bits are a plain MSB-first bit stream cut into bytes.
  task automatic model_sym(input psk8_sym_t s);
    logic [7:0] b;
    if (!in_pay) begin
      win_q.push_back(s);
      if (win_q.size() > 4) void'(win_q.pop_front());
      if (win_q.size() == 4 && {win_q[0], win_q[1], win_q[2], win_q[3]} == PSK8_SYNC_DEFAULT) begin
        fs_exp++;
        exp_fs_cyc = strobe_cyc + 3;
        in_pay = 1'b1;
        pay_n  = 0;
        bits_q.delete();
      end
    end else begin
      for (int k = 2; k >= 0; k--) bits_q.push_back(s[k]);
      pay_n++;
      if (bits_q.size() >= 8) begin
        for (int k = 0; k < 8; k++) b = {b[6:0], bits_q.pop_front()};
        exp_q.push_back(b);
      end
      if (pay_n == FRAME_SYMS) begin
        fe_exp++;
        in_pay = 1'b0;
        win_q.delete();
      end
    end
  endtask

  task automatic drive(input logic v, input logic signed [4:0] di, input logic signed [4:0] dq);
    sample_valid = v;
    i_in = di;
    q_in = dq;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'($urandom), 5'($urandom));
  endtask

  // One symbol = SPS accepted samples; phase 0 carries the decision point.
  task automatic send_sym(input psk8_sym_t s, input bit gaps, input bit rnd_noise);
    logic [9:0] pt;
    for (int p = 0; p < int'(SPS); p++) begin
      if (gaps) idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      if (p == 0) begin
        pt = point(s);
        strobe_cyc = cyc;
        drive(1'b1, pt[9:5], pt[4:0]);
        model_sym(s);
      end else begin
        pt = rnd_noise ? point(3'($urandom)) : point(3'b110);
        drive(1'b1, pt[9:5], pt[4:0]);
      end
    end
  endtask

  task automatic send_sync(input bit gaps, input bit rnd_noise);
    send_sym(3'b000, gaps, rnd_noise);
    send_sym(3'b011, gaps, rnd_noise);
    send_sym(3'b110, gaps, rnd_noise);
    send_sym(3'b101, gaps, rnd_noise);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_fs_count"}, 32'(fs_seen), 32'(fs_exp));
    check({tag, "_fe_count"}, 32'(fe_seen), 32'(fe_exp));
    check({tag, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_state"}, 32'(state_o), in_pay ? 32'd2 : 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_end", 32'(frame_end), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    idle(3);
    check("hunt_after_en", 32'(state_o), 32'd1);

    // Basic frame: sync then 16 x 001, always ready
    send_sync(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) send_sym(3'b001, 1'b0, 1'b1);
    idle(12);
    end_checks("basic");
    check("basic_overflow", 32'(overflow), 32'd0);
    check("basic_fe_last_byte", 32'(last_acc_cyc - fe_cyc), 32'd1);

    // Strobe phase: non-strobe phases carry (-4,0), sample_valid gaps
    send_sync(1'b1, 1'b0);
    for (int k = 0; k < 16; k++) send_sym(3'b001, 1'b1, 1'b0);
    idle(12);
    end_checks("phase");

    // Random frames with decoy prefixes that cannot contain the sync word
    for (int f = 0; f < 3; f++) begin
      for (int d = int'($urandom_range(0, 5)); d > 0; d--) send_sym(3'($urandom_range(1, 7)), 1'b1, 1'b1);
      send_sync(1'b1, 1'b1);
      for (int k = 0; k < 16; k++) send_sym(3'($urandom), 1'b1, 1'b1);
      idle(12);
      end_checks("random");
    end

    // Partial sync: first sync symbol, reset, then only the 3-symbol tail
    send_sym(3'b000, 1'b0, 1'b1);
    idle(1);
    rst_n = 1'b0;
    model_abort();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send_sym(3'b011, 1'b0, 1'b1);
    send_sym(3'b110, 1'b0, 1'b1);
    send_sym(3'b101, 1'b0, 1'b1);
    idle(10);
    end_checks("partial");
    check("partial_out_valid", 32'(out_valid), 32'd0);

    // Sparse ready: byte load may coincide with the handshake, no loss allowed
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin
      ready_k = k;
      send_sync(1'b0, 1'b1);
      for (int s = 0; s < 16; s++) send_sym(3'($urandom), 1'b0, 1'b1);
      idle(20);
      check("sparse_overflow", 32'(overflow), 32'd0);
      end_checks("sparse");
    end

    // Backpressure: sink never ready across a basic frame
    ready_mode = 1;
    out_ready = 1'b0;
    send_sync(1'b0, 1'b1);
    for (int k = 0; k < 16; k++) send_sym(3'b001, 1'b0, 1'b1);
    idle(12);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_held_byte", 32'(out_data), {24'd0, exp_q[0]});
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_fs_count", 32'(fs_seen), 32'(fs_exp));
    check("bp_fe_count", 32'(fe_seen), 32'(fe_exp));
    model_abort();
    en = 1'b0;
    idle(1);
    check("bp_en_state", 32'(state_o), 32'd0);
    check("bp_en_out_valid", 32'(out_valid), 32'd0);
    check("bp_en_overflow", 32'(overflow), 32'd0);
    en = 1'b1;
    idle(3);

    // Abort after 5 payload symbols, then a full sync is needed again
    send_sync(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send_sym(3'($urandom), 1'b0, 1'b1);
    idle(6);
    check("abort_pre_state", 32'(state_o), 32'd2);
    check("abort_pre_out_valid", 32'(out_valid), 32'd1);
    check("abort_pre_byte", 32'(out_data), {24'd0, exp_q[0]});
    model_abort();
    en = 1'b0;
    idle(1);
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    idle(2);
    en = 1'b1;
    ready_mode = 0;
    out_ready = 1'b1;
    idle(3);
    for (int k = 0; k < 10; k++) send_sym(3'b001, 1'b1, 1'b1);
    idle(6);
    end_checks("abort_nosync");
    send_sync(1'b1, 1'b1);
    for (int k = 0; k < 16; k++) send_sym(3'($urandom), 1'b1, 1'b1);
    idle(12);
    end_checks("abort_resync");

    // Asynchronous reset mid-payload
    ready_mode = 1;
    out_ready = 1'b0;
    send_sync(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send_sym(3'($urandom), 1'b0, 1'b1);
    idle(6);
    check("rst_pre_state", 32'(state_o), 32'd2);
    check("rst_pre_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_frame_start", 32'(frame_start), 32'd0);
    check("arst_frame_end", 32'(frame_end), 32'd0);
    model_abort();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;
    out_ready = 1'b1;
    idle(3);
    send_sync(1'b1, 1'b1);
    for (int k = 0; k < 16; k++) send_sym(3'($urandom), 1'b1, 1'b1);
    idle(12);
    end_checks("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psk8_rx_controller.md
# psk8_rx_controller

Receive-side sequencer for the 8-PSK demodulator. Decimates the I/Q sample stream to one decision point per symbol and feeds it to an internal `psk8_demodulator` instance. Hunts for a 4-symbol sync word, then packs a fixed-length payload of 3-bit symbols into bytes. Bytes leave on a valid/ready interface toward the byte sink / UART bridge.

## Interface
- `SPS`, default 4: samples per symbol; legal values 2..16.
- `STROBE_PHASE`, default 0: sample phase, in 0..SPS-1, taken as the symbol decision.
- `SYNC_WORD`, default 12'h0F5: symbols 000,011,110,101. The oldest symbol sits in bits [11:9].
- `FRAME_SYMS`, default 16: payload symbols per frame; must be a multiple of 8, range 8..248.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: receiver enable; low forces IDLE.
- `sample_valid`, in, 1: `i_in`/`q_in` carry a new sample this cycle.
- `i_in`, in, 5 signed: I sample.
- `q_in`, in, 5 signed: Q sample.
- `out_data`, out, 8: packed payload byte, MSB first.
- `out_valid`, out, 1: `out_data` valid.
- `out_ready`, in, 1: sink accepts the byte.
- `frame_start`, out, 1: one-cycle pulse when sync is detected.
- `frame_end`, out, 1: one-cycle pulse when the last payload symbol is packed.
- `overflow`, out, 1: sticky flag; a byte was dropped.
- `state_o`, out, 2: current state, encoded IDLE=0, HUNT=1, PAYLOAD=2.

## Operation
- States:
  - IDLE → HUNT when `en`=1.
  - HUNT → PAYLOAD on sync match.
  - PAYLOAD → HUNT after FRAME_SYMS symbols.
  - Any state → IDLE when `en`=0. This transition has priority over all others.
- Phase counter:
  - Counts accepted samples (`sample_valid`=1) modulo SPS.
  - Cleared to 0 on entry to HUNT; not cleared on HUNT↔PAYLOAD transitions.
  - A sample accepted at phase==STROBE_PHASE is a strobe. It is latched into a symbol I/Q register, which drives the demodulator.
  - Samples are ignored in IDLE.
- Symbol pipeline:
  - The strobe sample is latched at edge N.
  - The demodulator registers it at edge N+1.
  - `sym_valid` is a 2-stage shift of the strobe. The decision is consumed in the cycle after edge N+1.
- HUNT:
  - Each decision shifts into a 12-bit sync register, newest symbol in [2:0].
  - A 3-bit saturating count tracks symbols received.
  - Match = (count ≥ 4) and (register == SYNC_WORD), evaluated on the updated register.
  - On match: pulse `frame_start`, clear the symbol counter and the packer, enter PAYLOAD.
- PAYLOAD:
  - Each decision is appended MSB-first to a bit accumulator (≤10 bits plus a count).
  - When the count reaches ≥8, the top 8 bits form a byte and the count drops by 8. At most one byte is produced per symbol.
  - On symbol FRAME_SYMS: pulse `frame_end` in the same cycle as the final byte, clear the sync register and its count, return to HUNT. The sync word must be fully re-received.
- Output register:
  - A new byte loads when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle (no loss).
  - A new byte arriving while `out_valid`=1 and `out_ready`=0 is dropped and `overflow` is set.
  - A handshake (`out_valid`=1 and `out_ready`=1) with no new byte clears `out_valid`.
- `en`=0 clears: phase counter, symbol pipeline valids, sync register, packer, `out_valid`, `overflow`. The demodulator register is not cleared.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `frame_start`=0, `frame_end`=0, `overflow`=0, `state_o`=IDLE. All internal registers 0.
- Reset mid-frame abandons the frame immediately; no partial byte is emitted.
- Strobe sample to `frame_start` or byte-formed: 2 cycles. `out_valid` rises on the following edge (3 cycles from strobe).
- `frame_start` and `frame_end` are single-cycle pulses, aligned with the consuming decision cycle.
- Symbol-rate limit: one byte per symbol and SPS≥2, so the output sees at most one byte per 2 cycles.
- `en` falling during a pipelined strobe: the in-flight decision is discarded.

## Structure
- Package `psk8_pkg` holds:
  - `psk8_sym_t` (logic [2:0]).
  - state enum `psk8_rx_state_e`.
  - default sync constant `PSK8_SYNC_DEFAULT`.
- Sub-module `psk8_sym_packer` contains the 3-bit→byte accumulator. Ports: clear, sym_valid, sym, byte_valid, byte.
- Instantiates the existing `psk8_demodulator`.
- Constellation points used in the tests:
  - 000 = (+4,0), 001 = (+3,+3), 011 = (0,+4), 010 = (−3,+3)
  - 110 = (−4,0), 111 = (−3,−3), 101 = (0,−4), 100 = (+3,−3)

## Test plan
- Basic frame:
  - Stimulus: defaults, continuous samples; sync symbols 000,011,110,101 then 16 × 001.
  - Response: `frame_start` once; bytes 0x24,0x92,0x49,0x24,0x92,0x49 with `out_ready`=1; `frame_end` coincides with the 6th byte formed; `state_o` returns to HUNT.
- Partial sync:
  - Stimulus: 011,110,101 only, then idle.
  - Response: no `frame_start`, no bytes; a decoy 3-symbol tail after reset does not match.
- Strobe phase:
  - Stimulus: SPS=4; phases 1–3 carry (−4,0), only phase 0 carries the sync/payload points.
  - Response: same bytes as the basic-frame test; gaps in `sample_valid` do not advance the phase.
- Backpressure:
  - Stimulus: hold `out_ready`=0 across the basic frame.
  - Response: first byte 0x24 held, `overflow`=1 after the 2nd byte.
  - Stimulus: `out_ready`=1 in the same cycle a byte forms.
  - Response: new byte loads, no overflow.
- Abort:
  - Stimulus: drop `en` after 5 payload symbols, then re-raise it.
  - Response: IDLE next cycle, `out_valid`=0, `overflow`=0; the next frame requires a full sync.
- Reset:
  - Stimulus: assert `rst_n` low mid-payload.
  - Response: all outputs go to reset values asynchronously.
